pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and hazard-controller state encoding.
// Purely declarative; no latency and no flow control.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzstate_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: load in EX whose nonzero destination feeds a source in ID.
// Combinational, zero latency; stalls are applied by the caller.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dmemREN,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  // r0 is hardwired to zero, so a load into it never creates a dependency
  assign load_use = idex_dmemREN && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard control: latch enables/flushes from state and inputs.
// Outputs are combinational (zero latency); stalls hold upstream latches and bubble downstream.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  regbits_t    ifid_rs,
  input  regbits_t    ifid_rt,
  input  regbits_t    idex_rt,
  input  logic        idex_dmemREN,
  input  logic        exmem_dmemREN,
  input  logic        exmem_dmemWEN,
  input  logic        ex_redirect,
  input  logic        memwb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  hzstate_t state, next_state;
  logic     redirect_pending, next_pending;
  logic     load_use;
  logic     dmem_busy;
  logic     frozen;

  hazard_detect u_hazard_detect (
    .idex_dmemREN (idex_dmemREN),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use     (load_use)
  );

  assign dmem_busy = (exmem_dmemREN || exmem_dmemWEN) && !dhit;
  assign frozen    = !nRST || (state == HALTED) || ((state == DWAIT) && !dhit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state            <= RUN;
      redirect_pending <= 1'b0;
      stall_cycles     <= '0;
    end else begin
      state            <= next_state;
      redirect_pending <= next_pending;
      if (!pc_en && (state != HALTED) && (stall_cycles != STALL_MAX))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  always_comb begin
    next_state   = state;
    next_pending = redirect_pending;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    halted       = nRST && (state == HALTED);

    if (!frozen) begin
      if (memwb_halt) begin
        next_state = HALTED;
      end else if (dmem_busy) begin
        next_state = DWAIT;
      end else begin
        next_state = RUN;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        if (ex_redirect) begin
          idex_flush = 1'b1;
          if (ihit) begin
            ifid_flush   = 1'b1;
            next_pending = 1'b0;
          end else begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            next_pending = 1'b1;
          end
        end else begin
          if (load_use || !ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
          // the wrong-path instruction still parked in IF/ID is replaced by a bubble
          if (redirect_pending && ihit) begin
            ifid_en      = 1'b1;
            ifid_flush   = 1'b1;
            next_pending = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a table-driven reference model.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        idex_dmemREN, exmem_dmemREN, exmem_dmemWEN, ex_redirect, memwb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, halted;
  logic [15:0] stall_cycles;
  logic [7:0]  obs;

  int checks   = 0;
  int failures = 0;

  // reference model: mode 0=running, 1=waiting on dmem, 2=frozen
  int         m_mode = 0;
  bit         m_pend = 1'b0;
  int         m_cnt  = 0;
  int         nm;
  bit         np;
  logic [7:0] exp_o;

  localparam logic [7:0] ALL_ON   = 8'b11111_00_0;
  localparam logic [7:0] STALL_IF = 8'b00111_01_0;
  localparam logic [7:0] RDR_HIT  = 8'b11111_11_0;
  localparam logic [7:0] ALL_OFF  = 8'b00000_00_0;
  localparam logic [7:0] FROZEN   = 8'b00000_00_1;

  always #5 CLK = ~CLK;

  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};

  pipeline_hazard_ctrl dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .dhit          (dhit),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .idex_rt       (idex_rt),
    .idex_dmemREN  (idex_dmemREN),
    .exmem_dmemREN (exmem_dmemREN),
    .exmem_dmemWEN (exmem_dmemWEN),
    .ex_redirect   (ex_redirect),
    .memwb_halt    (memwb_halt),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .halted        (halted),
    .stall_cycles  (stall_cycles)
  );

  task automatic model_eval();
    bit lu;
    exp_o = ALL_OFF;
    nm    = m_mode;
    np    = m_pend;
    lu    = idex_dmemREN && (idex_rt != 5'd0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (!nRST) begin
      nm = 0;
      np = 1'b0;
    end else if (m_mode == 2) begin
      exp_o = FROZEN;
    end else if (m_mode == 1 && !dhit) begin
      exp_o = ALL_OFF;
    end else if (memwb_halt) begin
      nm = 2;
    end else if ((exmem_dmemREN || exmem_dmemWEN) && !dhit) begin
      nm = 1;
    end else begin
      nm = 0;
      if (ex_redirect && ihit) begin
        exp_o = RDR_HIT; np = 1'b0;
      end else if (ex_redirect) begin
        exp_o = STALL_IF; np = 1'b1;
      end else if (m_pend && ihit) begin
        exp_o = lu ? 8'b01111_11_0 : 8'b11111_10_0; np = 1'b0;
      end else if (lu || !ihit) begin
        exp_o = STALL_IF;
      end else begin
        exp_o = ALL_ON;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge CLK);
    if (!nRST) m_cnt = 0;
    else if (m_mode != 2 && !exp_o[7] && m_cnt < 65535) m_cnt = m_cnt + 1;
    m_mode = nm;
    m_pend = np;
    @(negedge CLK);
  endtask

  task automatic idle();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b1;
    idex_dmemREN = 1'b0; exmem_dmemREN = 1'b0; exmem_dmemWEN = 1'b0;
    ex_redirect = 1'b0; memwb_halt = 1'b0;
    ifid_rs = 5'($urandom_range(0, 31)); ifid_rt = 5'($urandom_range(0, 31));
    idex_rt = 5'($urandom_range(0, 31));
  endtask

  task automatic do_reset();
    idle(); nRST = 1'b0; tick(); nRST = 1'b1;
  endtask

  task automatic test_reset();
    idle(); nRST = 1'b0; ex_redirect = 1'b1; ihit = 1'b0; exmem_dmemREN = 1'b1; dhit = 1'b0;
    #1;
    checks++;
    if (obs !== ALL_OFF) begin failures++; $display("FAIL reset_outs got=%b want=%b", obs, ALL_OFF); end
    tick();
    checks++;
    if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", stall_cycles); end
    idle(); #1;
    checks++;
    if (obs !== ALL_ON) begin failures++; $display("FAIL reset_run got=%b want=%b", obs, ALL_ON); end
    tick();
  endtask

  task automatic test_load_use();
    idle(); idex_dmemREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7; #1;
    checks++;
    if (obs !== STALL_IF) begin failures++; $display("FAIL load_use_stall got=%b want=%b", obs, STALL_IF); end
    tick();
    idle(); #1;
    checks++;
    if (obs !== ALL_ON) begin failures++; $display("FAIL load_use_release got=%b want=%b", obs, ALL_ON); end
    tick();
    idle(); idex_dmemREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    checks++;
    if (obs !== ALL_ON) begin failures++; $display("FAIL load_r0 got=%b want=%b", obs, ALL_ON); end
    tick();
    idle(); idex_dmemREN = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; #1;
    checks++;
    if (obs !== STALL_IF) begin failures++; $display("FAIL load_use_rt got=%b want=%b", obs, STALL_IF); end
    tick();
  endtask

  task automatic test_dmem_wait();
    int base;
    idle(); tick();
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      idle(); exmem_dmemREN = 1'b1; dhit = 1'b0; #1;
      checks++;
      if (obs !== ALL_OFF) begin failures++; $display("FAIL dwait_c%0d got=%b want=%b", i, obs, ALL_OFF); end
      tick();
    end
    idle(); exmem_dmemREN = 1'b1; dhit = 1'b1; #1;
    checks++;
    if (obs !== ALL_ON) begin failures++; $display("FAIL dwait_release got=%b want=%b", obs, ALL_ON); end
    checks++;
    if (stall_cycles !== 16'(base + 3)) begin
      failures++; $display("FAIL dwait_count got=%0d want=%0d", stall_cycles, base + 3);
    end
    tick();
    idle(); exmem_dmemWEN = 1'b1; dhit = 1'b0; tick();
    idle(); nRST = 1'b0; dhit = 1'b0; tick();
    idle(); #1;
    checks++;
    if (obs !== ALL_ON) begin failures++; $display("FAIL dwait_reset got=%b want=%b", obs, ALL_ON); end
    tick();
  endtask

  task automatic test_redirect();
    logic [7:0] want [4];
    want[0] = STALL_IF; want[1] = STALL_IF; want[2] = 8'b11111_10_0; want[3] = ALL_ON;
    for (int i = 0; i < 4; i++) begin
      idle();
      ex_redirect = (i == 0);
      ihit        = (i >= 2);
      #1;
      checks++;
      if (obs !== want[i]) begin failures++; $display("FAIL redirect_c%0d got=%b want=%b", i, obs, want[i]); end
      tick();
    end
    idle(); ex_redirect = 1'b1; #1;
    checks++;
    if (obs !== RDR_HIT) begin failures++; $display("FAIL redirect_hit got=%b want=%b", obs, RDR_HIT); end
    tick();
  endtask

  task automatic test_halt();
    int held;
    idle(); memwb_halt = 1'b1; ex_redirect = 1'b1; #1;
    checks++;
    if (obs !== ALL_OFF) begin failures++; $display("FAIL halt_entry got=%b want=%b", obs, ALL_OFF); end
    tick();
    held = m_cnt;
    for (int i = 0; i < 4; i++) begin
      idle(); ex_redirect = 1'($urandom_range(0, 1)); ihit = 1'($urandom_range(0, 1));
      exmem_dmemREN = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1)); #1;
      checks++;
      if (obs !== FROZEN) begin failures++; $display("FAIL halt_sticky got=%b want=%b", obs, FROZEN); end
      tick();
    end
    checks++;
    if (stall_cycles !== 16'(held)) begin failures++; $display("FAIL halt_count got=%0d want=%0d", stall_cycles, held); end
    idle(); nRST = 1'b0; #1;
    checks++;
    if (obs !== ALL_OFF) begin failures++; $display("FAIL halt_reset got=%b want=%b", obs, ALL_OFF); end
    tick();
    idle(); #1;
    checks++;
    if (obs !== ALL_ON) begin failures++; $display("FAIL halt_exit got=%b want=%b", obs, ALL_ON); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      nRST          = ($urandom_range(0, 149) != 0);
      ihit          = ($urandom_range(0, 3) != 0);
      dhit          = ($urandom_range(0, 2) != 0);
      exmem_dmemREN = ($urandom_range(0, 3) == 0);
      exmem_dmemWEN = ($urandom_range(0, 5) == 0);
      ex_redirect   = ($urandom_range(0, 5) == 0);
      memwb_halt    = ($urandom_range(0, 99) == 0);
      idex_dmemREN  = 1'($urandom_range(0, 1));
      idex_rt       = 5'($urandom_range(0, 3));
      ifid_rs       = 5'($urandom_range(0, 3));
      ifid_rt       = 5'($urandom_range(0, 3));
      #1;
      model_eval();
      checks++;
      if (obs !== exp_o) begin failures++; $display("FAIL random_outs cyc=%0d got=%b want=%b", i, obs, exp_o); end
      checks++;
      if (stall_cycles !== 16'(m_cnt)) begin
        failures++; $display("FAIL random_count cyc=%0d got=%0d want=%0d", i, stall_cycles, m_cnt);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      idle(); exmem_dmemREN = 1'b1; dhit = 1'b0; tick();
    end
    #1;
    checks++;
    if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h want=ffff", stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      idle(); ihit = 1'b0; tick();
    end
    #1;
    checks++;
    if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h want=ffff", stall_cycles); end
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_redirect();
    test_halt();
    do_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
